lvds_panel_sequencer: RTL and testbench
=======================================

Name: lvds_panel_sequencer

Overview:
Power and enable sequencer for the dual-link LVDS panel path: pixel timing generator, DDR gearbox and LP171WU3-class panel. Drives panel VDD, the active-low reset of the timing/gearbox datapath, backlight enable and backlight PWM, in the order and with the delays the panel power sequence requires. Backlight turn-on is aligned to a frame boundary reported by the timing generator. Runs in the pixel clock domain (fast clock / 3.5).

Parameters:
CNT_W, 27, width of the delay counters
T_VDD_LVDS, 514286, cycles from VDD on to LVDS release (10 ms at 51.43 MHz)
T_LVDS_BL, 10285714, cycles from LVDS release to backlight arm (200 ms)
T_BL_LVDS, 10285714, cycles from backlight off to LVDS reset (200 ms)
T_LVDS_VDD, 514286, cycles from LVDS reset to VDD off (10 ms)
T_OFF_MIN, 51428571, minimum cycles VDD stays off before re-power (1 s)
T_ARM_TO, 2000000, cycles to wait for a frame start before forcing backlight on
PWM_DIV, 200, pixel clocks per PWM step (255 steps per PWM period)

Ports:
i_clk  in  1  pixel clock
i_reset  in  1  synchronous reset, active-high
i_enable  in  1  level request: panel on (1) or off (0)
i_pll_lock  in  1  fast/pixel PLL locked
i_frame_start  in  1  single-cycle pulse at h=0, v=0 from timing generator
i_brightness  in  8  backlight duty, 0 = off, 255 = full on
o_panel_vdd  out  1  panel VDD enable
o_lvds_resetn  out  1  active-low reset to timing generator and gearbox
o_bl_en  out  1  backlight enable
o_bl_pwm  out  1  backlight PWM
o_ready  out  1  panel fully on (state ON)
o_timing_fault  out  1  sticky: frame start timeout occurred
o_state  out  3  current state encoding

Behaviour:
- All outputs are registered. Reset values: o_panel_vdd=0, o_lvds_resetn=0, o_bl_en=0, o_bl_pwm=0, o_ready=0, o_timing_fault=0, o_state=OFF.
- On reset, the off-timer loads T_OFF_MIN-1. VDD always stays off for at least T_OFF_MIN cycles after reset.
- Delay timer: loads T-1 on state entry. The state exits on the cycle the timer reads 0, so the state lasts exactly T cycles.
- go = i_enable & i_pll_lock.
- States and encodings:
  - OFF (0): all outputs 0. The off-timer counts down to 0 and then holds. Go to VDD when go=1 and the off-timer is 0.
  - VDD (1): o_panel_vdd=1. After T_VDD_LVDS, go to LVDS. If go=0, go to LVDS_OFF.
  - LVDS (2): o_lvds_resetn=1. After T_LVDS_BL, go to ARM. If go=0, go to LVDS_OFF.
  - ARM (3): wait for i_frame_start, then go to ON. If T_ARM_TO cycles pass without it, go to ON and set o_timing_fault. If go=0, go to LVDS_OFF.
  - ON (4): o_bl_en=1, o_ready=1, PWM active. If go=0, go to BL_OFF.
  - BL_OFF (5): o_bl_en=0, o_bl_pwm=0, o_ready=0. After T_BL_LVDS, go to LVDS_OFF.
  - LVDS_OFF (6): o_lvds_resetn=0, VDD still 1. After T_LVDS_VDD, go to OFF and reload the off-timer with T_OFF_MIN-1.
- Outputs change in the same cycle o_state shows the new state.
- Power-down is not abortable. Re-asserting i_enable during BL_OFF or LVDS_OFF has no effect until OFF is reached and the off-timer expires.
- i_frame_start arriving in the same cycle that go drops while in ARM: go=0 wins, next state is LVDS_OFF.
- i_frame_start outside ARM is ignored.
- PWM:
  - On entry to ON, the prescaler and the step counter reset to 0 and i_brightness is latched.
  - The step counter advances every PWM_DIV cycles and wraps 254 -> 0.
  - i_brightness is re-latched when the step counter wraps to 0.
  - o_bl_pwm = (step < latched brightness). Brightness 0 gives constant 0; 255 gives constant 1.
- o_timing_fault is cleared only by i_reset.

Test Plan:
All scenarios use T_VDD_LVDS=4, T_LVDS_BL=8, T_BL_LVDS=6, T_LVDS_VDD=3, T_OFF_MIN=20, T_ARM_TO=50, PWM_DIV=1.
1. Power-up: release reset, hold i_enable=1 and i_pll_lock=1, pulse i_frame_start at cycle 40 -> VDD rises at cycle 20, o_lvds_resetn rises 4 cycles later, ARM is entered 8 cycles after that, o_bl_en and o_ready rise the cycle after the pulse.
2. Power-down from ON: drop i_enable -> o_bl_en falls immediately, o_lvds_resetn falls 6 cycles later, o_panel_vdd falls 3 cycles after that, state is OFF.
3. Fast re-enable: raise i_enable one cycle after OFF is reached -> VDD stays off for exactly 20 cycles, then the sequence restarts.
4. Abort mid-sequence: drop i_pll_lock in LVDS -> LVDS_OFF next cycle, VDD off after 3 cycles, o_bl_en never asserted.
5. Frame timeout: no i_frame_start in ARM -> ON after 50 cycles, o_timing_fault=1 and stays 1 through a full power cycle until i_reset.
6. PWM: brightness 64 in ON -> o_bl_pwm high 64 of every 255 cycles. Change to 128 mid-period -> the new duty takes effect only from the next wrap. Brightness 0 -> constant low; 255 -> constant high.

Source files
------------

// File: rtl/lvds_panel_sequencer.sv
// Panel power/enable sequencer: walks VDD, LVDS datapath reset and backlight through
// the panel's power-on/off order, with frame-aligned backlight turn-on and PWM dimming.
module lvds_panel_sequencer #(
  parameter int unsigned CNT_W      = 27,
  parameter int unsigned T_VDD_LVDS = 514286,
  parameter int unsigned T_LVDS_BL  = 10285714,
  parameter int unsigned T_BL_LVDS  = 10285714,
  parameter int unsigned T_LVDS_VDD = 514286,
  parameter int unsigned T_OFF_MIN  = 51428571,
  parameter int unsigned T_ARM_TO   = 2000000,
  parameter int unsigned PWM_DIV    = 200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_pll_lock,
  input  logic       i_frame_start,
  input  logic [7:0] i_brightness,
  output logic       o_panel_vdd,
  output logic       o_lvds_resetn,
  output logic       o_bl_en,
  output logic       o_bl_pwm,
  output logic       o_ready,
  output logic       o_timing_fault,
  output logic [2:0] o_state
);

  localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_VDD      = 3'd1,
    S_LVDS     = 3'd2,
    S_ARM      = 3'd3,
    S_ON       = 3'd4,
    S_BL_OFF   = 3'd5,
    S_LVDS_OFF = 3'd6
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_dly, r_off, w_dly_load;
  logic [PRE_W-1:0]   r_pre, w_pre_nxt;
  logic [7:0]         r_step, w_step_nxt, r_bri, w_bri_nxt;
  logic               r_vdd, r_resetn, r_on, r_pwm, r_fault;
  logic               w_go, w_enter, w_enter_on, w_pre_wrap, w_fault_set;

  assign w_go       = i_enable & i_pll_lock;
  assign w_enter    = (w_state_nxt != r_state);
  assign w_enter_on = (w_state_nxt == S_ON) && (r_state != S_ON);

  // Next-state: go=0 outranks every forward transition, power-down runs to completion
  always_comb begin
    w_state_nxt = r_state;
    w_fault_set = 1'b0;
    case (r_state)
      S_OFF:      if (w_go && r_off == '0) w_state_nxt = S_VDD;
      S_VDD:      if (!w_go) w_state_nxt = S_LVDS_OFF;
                  else if (r_dly == '0) w_state_nxt = S_LVDS;
      S_LVDS:     if (!w_go) w_state_nxt = S_LVDS_OFF;
                  else if (r_dly == '0) w_state_nxt = S_ARM;
      S_ARM: begin
        if (!w_go) w_state_nxt = S_LVDS_OFF;
        else if (i_frame_start) w_state_nxt = S_ON;
        else if (r_dly == '0) begin
          w_state_nxt = S_ON;
          w_fault_set = 1'b1;
        end
      end
      S_ON:       if (!w_go) w_state_nxt = S_BL_OFF;
      S_BL_OFF:   if (r_dly == '0) w_state_nxt = S_LVDS_OFF;
      S_LVDS_OFF: if (r_dly == '0) w_state_nxt = S_OFF;
      default:    w_state_nxt = S_OFF;
    endcase
  end

  always_comb begin
    w_dly_load = '0;
    case (w_state_nxt)
      S_VDD:      w_dly_load = CNT_W'(T_VDD_LVDS - 1);
      S_LVDS:     w_dly_load = CNT_W'(T_LVDS_BL - 1);
      S_ARM:      w_dly_load = CNT_W'(T_ARM_TO - 1);
      S_BL_OFF:   w_dly_load = CNT_W'(T_BL_LVDS - 1);
      S_LVDS_OFF: w_dly_load = CNT_W'(T_LVDS_VDD - 1);
      default:    w_dly_load = '0;
    endcase
  end

  // PWM: step advances once per prescaler wrap; brightness only re-latched at period start
  always_comb begin
    w_pre_wrap = (r_pre == PRE_W'(PWM_DIV - 1));
    w_pre_nxt  = r_pre + PRE_W'(1);
    w_step_nxt = r_step;
    w_bri_nxt  = r_bri;
    if (w_enter_on) begin
      w_pre_nxt  = '0;
      w_step_nxt = '0;
      w_bri_nxt  = i_brightness;
    end else if (w_pre_wrap) begin
      w_pre_nxt = '0;
      if (r_step == 8'd254) begin
        w_step_nxt = '0;
        w_bri_nxt  = i_brightness;
      end else begin
        w_step_nxt = r_step + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_OFF;
    else         r_state <= w_state_nxt;
  end

  // Outputs are decoded from the next state so they change together with o_state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_off    <= CNT_W'(T_OFF_MIN - 1);
      r_vdd    <= 1'b0;
      r_resetn <= 1'b0;
      r_on     <= 1'b0;
      r_pwm    <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (w_enter && w_state_nxt == S_OFF) r_off <= CNT_W'(T_OFF_MIN - 1);
      else if (r_state == S_OFF && r_off != '0) r_off <= r_off - CNT_W'(1);
      r_vdd    <= (w_state_nxt != S_OFF);
      r_resetn <= (w_state_nxt == S_LVDS) || (w_state_nxt == S_ARM) ||
                  (w_state_nxt == S_ON)   || (w_state_nxt == S_BL_OFF);
      r_on     <= (w_state_nxt == S_ON);
      r_pwm    <= (w_state_nxt == S_ON) && (w_step_nxt < w_bri_nxt);
      r_fault  <= r_fault | w_fault_set;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enter) r_dly <= w_dly_load;
    else if (r_dly != '0) r_dly <= r_dly - CNT_W'(1);
    r_pre  <= w_pre_nxt;
    r_step <= w_step_nxt;
    r_bri  <= w_bri_nxt;
  end

  assign o_panel_vdd    = r_vdd;
  assign o_lvds_resetn  = r_resetn;
  assign o_bl_en        = r_on;
  assign o_ready        = r_on;
  assign o_bl_pwm       = r_pwm;
  assign o_timing_fault = r_fault;
  assign o_state        = r_state;

endmodule

// File: tb/tb_lvds_panel_sequencer.sv
// Bench for lvds_panel_sequencer: directed power sequences plus random traffic,
// compared cycle by cycle against a phase/age reference model.
module tb_lvds_panel_sequencer;

  localparam int TVL = 4, TLB = 8, TBL = 6, TLV = 3, TOFF = 20, TARM = 50, PDIV = 1;

  logic       clk = 1'b0;
  logic       rst, en, lock, fs;
  logic [7:0] bri;
  logic       o_vdd, o_rn, o_bl, o_pwm, o_rdy, o_flt;
  logic [2:0] o_st;

  always #5 clk = ~clk;

  lvds_panel_sequencer #(
    .CNT_W(27), .T_VDD_LVDS(TVL), .T_LVDS_BL(TLB), .T_BL_LVDS(TBL),
    .T_LVDS_VDD(TLV), .T_OFF_MIN(TOFF), .T_ARM_TO(TARM), .PWM_DIV(PDIV)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_pll_lock(lock),
    .i_frame_start(fs), .i_brightness(bri),
    .o_panel_vdd(o_vdd), .o_lvds_resetn(o_rn), .o_bl_en(o_bl), .o_bl_pwm(o_pwm),
    .o_ready(o_rdy), .o_timing_fault(o_flt), .o_state(o_st)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;

  // Reference model: phase number, cycles spent in phase, cycles spent in ON
  int   m_ph = 0, m_age = 0, m_on = 0;
  logic m_fault = 1'b0;
  int   m_bri = 0;

  int   t_vdd_up = -1, t_vdd_dn = -1, t_rn_up = -1, t_rn_dn = -1;
  int   t_bl_up = -1, t_bl_dn = -1, t_flt_up = -1, t_arm = -1;
  logic p_vdd = 1'b0, p_rn = 1'b0, p_bl = 1'b0, p_flt = 1'b0;
  logic [2:0] p_st = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    bit go;
    int nxt;
    go  = en & lock;
    nxt = m_ph;
    if (rst) begin
      m_ph = 0; m_age = 0; m_fault = 1'b0;
      return;
    end
    case (m_ph)
      0: if (go && m_age >= TOFF - 1) nxt = 1;
      1: if (!go) nxt = 6; else if (m_age == TVL - 1) nxt = 2;
      2: if (!go) nxt = 6; else if (m_age == TLB - 1) nxt = 3;
      3: if (!go) nxt = 6;
         else if (fs) nxt = 4;
         else if (m_age == TARM - 1) begin nxt = 4; m_fault = 1'b1; end
      4: if (!go) nxt = 5;
      5: if (m_age == TBL - 1) nxt = 6;
      6: if (m_age == TLV - 1) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt != m_ph) begin
      if (nxt == 4) begin m_on = 0; m_bri = int'(bri); end
      m_ph = nxt; m_age = 0;
    end else begin
      m_age++;
      if (m_ph == 4) begin
        m_on++;
        if (m_on % (255 * PDIV) == 0) m_bri = int'(bri);
      end
    end
  endtask

  task automatic cmp_all();
    bit on;
    on = (m_ph == 4);
    chk("state",  32'(o_st), 32'(m_ph));
    chk("vdd",    32'(o_vdd), 32'(m_ph != 0));
    chk("resetn", 32'(o_rn), 32'(m_ph >= 2 && m_ph <= 5));
    chk("bl_en",  32'(o_bl), 32'(on));
    chk("ready",  32'(o_rdy), 32'(on));
    chk("pwm",    32'(o_pwm), 32'(on && (((m_on / PDIV) % 255) < m_bri)));
    chk("fault",  32'(o_flt), 32'(m_fault));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    cmp_all();
    if (o_vdd && !p_vdd) t_vdd_up = cyc;
    if (!o_vdd && p_vdd) t_vdd_dn = cyc;
    if (o_rn && !p_rn)   t_rn_up = cyc;
    if (!o_rn && p_rn)   t_rn_dn = cyc;
    if (o_bl && !p_bl)   t_bl_up = cyc;
    if (!o_bl && p_bl)   t_bl_dn = cyc;
    if (o_flt && !p_flt) t_flt_up = cyc;
    if (o_st == 3'd3 && p_st != 3'd3) t_arm = cyc;
    p_vdd = o_vdd; p_rn = o_rn; p_bl = o_bl; p_flt = o_flt; p_st = o_st;
  endtask

  task automatic run_cnt(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      tick();
      hi += int'(o_pwm);
    end
  endtask

  initial begin
    int t0, t1, h, h2, blsum;
    rst = 1'b1; en = 1'b0; lock = 1'b0; fs = 1'b0; bri = 8'd0;
    tick();

    // Power-up with a frame start at cycle 40 after reset
    en = 1'b1; lock = 1'b1; bri = 8'd64;
    tick();
    rst = 1'b0;
    t0 = cyc;
    for (int n = 1; n <= 40; n++) begin
      fs = (n == 40);
      tick();
    end
    fs = 1'b0;
    chk("pu_vdd_t", 32'(t_vdd_up - t0), 32'd20);
    chk("pu_rn_t",  32'(t_rn_up - t0),  32'd24);
    chk("pu_arm_t", 32'(t_arm - t0),    32'd32);
    chk("pu_bl_t",  32'(t_bl_up - t0),  32'd40);

    // PWM duty over whole periods, mid-period change deferred to the next wrap
    h = int'(o_pwm);
    run_cnt(254, h2);
    chk("pwm64", 32'(h + h2), 32'd64);
    run_cnt(100, h);
    bri = 8'd128;
    run_cnt(155, h2);
    chk("pwm_hold", 32'(h + h2), 32'd64);
    run_cnt(255, h);
    chk("pwm128", 32'(h), 32'd128);
    bri = 8'd0;
    run_cnt(255, h);
    chk("pwm0", 32'(h), 32'd0);
    bri = 8'd255;
    run_cnt(255, h);
    chk("pwm255", 32'(h), 32'd255);

    // Power-down from ON
    t0 = cyc;
    en = 1'b0;
    repeat (10) tick();
    chk("pd_bl_t",  32'(t_bl_dn - t0),  32'd1);
    chk("pd_rn_t",  32'(t_rn_dn - t0),  32'd7);
    chk("pd_vdd_t", 32'(t_vdd_dn - t0), 32'd10);
    chk("pd_state", 32'(o_st), 32'd0);

    // Fast re-enable one cycle after OFF is reached
    en = 1'b1;
    repeat (25) tick();
    chk("off_min", 32'(t_vdd_up - t_vdd_dn), 32'd20);
    chk("reen_state", 32'(o_st), 32'd2);

    // PLL lock lost during LVDS
    lock = 1'b0;
    blsum = 0;
    tick();
    blsum += int'(o_bl);
    chk("abort_state", 32'(o_st), 32'd6);
    t1 = cyc;
    repeat (4) begin
      tick();
      blsum += int'(o_bl);
    end
    chk("abort_vdd_t", 32'(t_vdd_dn - t1), 32'd3);
    chk("abort_bl", 32'(blsum), 32'd0);

    // Frame start never arrives: forced ON with sticky fault
    lock = 1'b1;
    repeat (85) tick();
    chk("to_fault_t", 32'(t_flt_up - t_vdd_dn), 32'd82);
    chk("to_ready", 32'(o_rdy), 32'd1);
    en = 1'b0;
    repeat (15) tick();
    chk("to_off_state", 32'(o_st), 32'd0);
    chk("to_fault_off", 32'(o_flt), 32'd1);
    en = 1'b1;
    repeat (40) tick();
    chk("to_fault_on", 32'(o_flt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_fault", 32'(o_flt), 32'd0);
    chk("rst_state", 32'(o_st), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      if (lock) begin
        if ($urandom_range(0, 499) == 0) lock = 1'b0;
      end else if ($urandom_range(0, 19) == 0) lock = 1'b1;
      fs  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 99) == 0) bri = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0; fs = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
